// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl
// Brief    : Single-outstanding load/store unit with a req/gnt/rvalid data bus,
//            load alignment/extension and fault reporting to writeback.
//            Optional macro LSU_MISALIGN_EXC_EN traps misaligned accesses.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_ctrl #(
  parameter int XLEN        = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_op,
  input  logic [XLEN-1:0]   in_base,
  input  logic [XLEN-1:0]   in_offset,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [4:0]        in_rd,
  output logic              dbus_req,
  input  logic              dbus_gnt,
  output logic              dbus_wr,
  output logic [XLEN/8-1:0] dbus_be,
  output logic [XLEN-1:0]   dbus_addr,
  output logic [XLEN-1:0]   dbus_wdata,
  input  logic              dbus_rvalid,
  input  logic [XLEN-1:0]   dbus_rdata,
  input  logic              dbus_err,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [XLEN-1:0]   wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_exc,
  output logic [1:0]        wb_exc_code,
  output logic [XLEN-1:0]   wb_addr
);

  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit TO_EN = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       size_q;
  logic             uns_q;
  logic [OFF_W-1:0] off_q;

  logic             w_mem_en, w_we, w_uns, w_illegal, w_timeout;
  logic [3:0]       w_size;
  logic [XLEN-1:0]  w_sum, w_addr, w_wdata, w_shift, w_load;
  logic [OFF_W-1:0] w_mask, w_off;
  logic [BE_W-1:0]  w_be;
`ifdef LSU_MISALIGN_EXC_EN
  logic             w_mis;
`endif

  // size is one-hot {D,W,H,B} in bits [3:0]
  always_comb begin
    w_mem_en  = in_op[6];
    w_we      = in_op[5];
    w_size    = in_op[4:1];
    w_uns     = in_op[0];
    w_sum     = in_base + in_offset;
    w_illegal = !$onehot(w_size) || (w_size[3] && (XLEN == 32));
    w_mask    = '0;
    if (w_size[3])      w_mask = '1;
    else if (w_size[2]) w_mask = OFF_W'(3);
    else if (w_size[1]) w_mask = OFF_W'(1);
`ifdef LSU_MISALIGN_EXC_EN
    w_mis  = (w_sum[OFF_W-1:0] & w_mask) != '0;
    w_addr = w_sum;
`else
    w_addr = w_sum & ~{{(XLEN-OFF_W){1'b0}}, w_mask};
`endif
    w_off = w_addr[OFF_W-1:0];
    if (w_size[3])      w_be = '1;
    else if (w_size[2]) w_be = BE_W'(4'hF) << w_off;
    else if (w_size[1]) w_be = BE_W'(2'b11) << w_off;
    else                w_be = BE_W'(1) << w_off;
    if (w_size[3])      w_wdata = in_wdata;
    else if (w_size[2]) w_wdata = {(XLEN/32){in_wdata[31:0]}};
    else if (w_size[1]) w_wdata = {(BE_W/2){in_wdata[15:0]}};
    else                w_wdata = {BE_W{in_wdata[7:0]}};
  end

  always_comb begin
    w_shift = dbus_rdata >> {off_q, 3'b000};
    case (size_q)
      4'b0001: w_load = uns_q ? XLEN'(w_shift[7:0])  : XLEN'($signed(w_shift[7:0]));
      4'b0010: w_load = uns_q ? XLEN'(w_shift[15:0]) : XLEN'($signed(w_shift[15:0]));
      4'b0100: w_load = uns_q ? XLEN'(w_shift[31:0]) : XLEN'($signed(w_shift[31:0]));
      default: w_load = w_shift;
    endcase
    w_timeout = TO_EN && (cnt == TO_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      off_q       <= '0;
      in_ready    <= 1'b1;
      dbus_req    <= 1'b0;
      dbus_wr     <= 1'b0;
      dbus_be     <= '0;
      dbus_addr   <= '0;
      dbus_wdata  <= '0;
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      wb_rd       <= '0;
      wb_exc      <= 1'b0;
      wb_exc_code <= '0;
      wb_addr     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            cnt <= '0;
            if (w_mem_en) begin
              in_ready    <= 1'b0;
              size_q      <= w_size;
              uns_q       <= w_uns;
              off_q       <= w_off;
              wb_rd       <= in_rd;
              wb_addr     <= w_addr;
              wb_data     <= '0;
              wb_exc      <= 1'b0;
              wb_exc_code <= 2'd0;
              if (w_illegal) begin
                state       <= S_RESP;
                wb_valid    <= 1'b1;
                wb_exc      <= 1'b1;
                wb_exc_code <= 2'd3;
                wb_addr     <= w_sum;
`ifdef LSU_MISALIGN_EXC_EN
              end else if (w_mis) begin
                state       <= S_RESP;
                wb_valid    <= 1'b1;
                wb_exc      <= 1'b1;
                wb_exc_code <= 2'd0;
`endif
              end else begin
                state      <= S_REQ;
                dbus_req   <= 1'b1;
                dbus_wr    <= w_we;
                dbus_be    <= w_we ? w_be : '0;
                dbus_addr  <= w_addr;
                dbus_wdata <= w_wdata;
              end
            end
          end
        end
        S_REQ: begin
          cnt <= cnt + 1'b1;
          if (dbus_gnt) begin
            dbus_req <= 1'b0;
            state    <= S_WAIT;
          end else if (w_timeout) begin
            dbus_req    <= 1'b0;
            state       <= S_RESP;
            wb_valid    <= 1'b1;
            wb_exc      <= 1'b1;
            wb_exc_code <= 2'd2;
          end
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (dbus_rvalid) begin
            state    <= S_RESP;
            wb_valid <= 1'b1;
            if (dbus_err) begin
              wb_exc      <= 1'b1;
              wb_exc_code <= 2'd1;
            end else if (!dbus_wr) begin
              wb_data <= w_load;
            end
          end else if (w_timeout) begin
            state       <= S_RESP;
            wb_valid    <= 1'b1;
            wb_exc      <= 1'b1;
            wb_exc_code <= 2'd2;
          end
        end
        default: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            in_ready <= 1'b1;
            state    <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_ctrl
// Brief    : Directed self-checking bench for lsu_ctrl (XLEN=64, TIMEOUT_CYC=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;

  localparam logic [6:0] OP_LB  = 7'b1_0_0001_0;
  localparam logic [6:0] OP_LBU = 7'b1_0_0001_1;
  localparam logic [6:0] OP_SH  = 7'b1_1_0010_0;
  localparam logic [6:0] OP_LW  = 7'b1_0_0100_0;
  localparam logic [6:0] OP_LD  = 7'b1_0_1000_0;
  localparam logic [6:0] OP_SD  = 7'b1_1_1000_0;
  localparam logic [6:0] OP_BAD = 7'b1_0_0011_0;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [6:0]  in_op;
  logic [63:0] in_base, in_offset, in_wdata;
  logic [4:0]  in_rd;
  logic        dbus_req, dbus_gnt, dbus_wr;
  logic [7:0]  dbus_be;
  logic [63:0] dbus_addr, dbus_wdata;
  logic        dbus_rvalid, dbus_err;
  logic [63:0] dbus_rdata;
  logic        wb_valid, wb_ready;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_exc;
  logic [1:0]  wb_exc_code;
  logic [63:0] wb_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.XLEN(64), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_base(in_base), .in_offset(in_offset), .in_wdata(in_wdata), .in_rd(in_rd),
    .dbus_req(dbus_req), .dbus_gnt(dbus_gnt), .dbus_wr(dbus_wr), .dbus_be(dbus_be),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
    .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata), .dbus_err(dbus_err),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_exc(wb_exc), .wb_exc_code(wb_exc_code), .wb_addr(wb_addr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // inputs change and outputs are sampled 1 time unit after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [63:0] base, input logic [63:0] off,
                       input logic [63:0] wd, input logic [4:0] rd);
    in_valid  = 1'b1;
    in_op     = op;
    in_base   = base;
    in_offset = off;
    in_wdata  = wd;
    in_rd     = rd;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic grant_and_respond(input logic [63:0] rdata, input logic err);
    dbus_gnt = 1'b1;
    tick();
    dbus_gnt    = 1'b0;
    dbus_rvalid = 1'b1;
    dbus_rdata  = rdata;
    dbus_err    = err;
    tick();
    dbus_rvalid = 1'b0;
    dbus_err    = 1'b0;
  endtask

  task automatic release_wb();
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_base = '0; in_offset = '0;
    in_wdata = '0; in_rd = '0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
    dbus_rdata = '0; dbus_err = 1'b0; wb_ready = 1'b0;
    tick(); tick();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_req", dbus_req, 1'b0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_exc", wb_exc, 1'b0);
    check("rst_wb_data", wb_data, 64'h0);
    check("rst_dbus_addr", dbus_addr, 64'h0);
    rst = 1'b0;
    tick();

    // LB with negative byte in lane 3
    issue(OP_LB, 64'h1000, 64'h3, 64'h0, 5'd5);
    check("lb_req", dbus_req, 1'b1);
    check("lb_in_ready", in_ready, 1'b0);
    check("lb_addr", dbus_addr, 64'h1003);
    check("lb_wr", dbus_wr, 1'b0);
    check("lb_be", dbus_be, 8'h00);
    dbus_gnt = 1'b1;
    tick();
    dbus_gnt = 1'b0;
    check("lb_req_drop", dbus_req, 1'b0);
    check("lb_wait_no_wb", wb_valid, 1'b0);
    dbus_rvalid = 1'b1;
    dbus_rdata  = 64'h0000_0000_8000_0000;
    tick();
    dbus_rvalid = 1'b0;
    check("lb_wb_valid", wb_valid, 1'b1);
    check("lb_wb_data", wb_data, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_wb_rd", wb_rd, 5'd5);
    check("lb_wb_exc", wb_exc, 1'b0);
    release_wb();
    check("lb_done_valid", wb_valid, 1'b0);
    check("lb_done_ready", in_ready, 1'b1);

    // SH to upper halfword lanes
    issue(OP_SH, 64'h1000, 64'h6, 64'h1234, 5'd6);
    check("sh_wr", dbus_wr, 1'b1);
    check("sh_be", dbus_be, 8'hC0);
    check("sh_wdata", dbus_wdata, 64'h1234_1234_1234_1234);
    check("sh_addr", dbus_addr, 64'h1006);
    grant_and_respond(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    check("sh_wb_valid", wb_valid, 1'b1);
    check("sh_wb_exc", wb_exc, 1'b0);
    check("sh_wb_data", wb_data, 64'h0);
    release_wb();

    // LW at a misaligned address
    issue(OP_LW, 64'h1000, 64'h2, 64'h0, 5'd7);
`ifdef LSU_MISALIGN_EXC_EN
    check("lw_mis_req", dbus_req, 1'b0);
    check("lw_mis_valid", wb_valid, 1'b1);
    check("lw_mis_exc", wb_exc, 1'b1);
    check("lw_mis_code", wb_exc_code, 2'd0);
    check("lw_mis_addr", wb_addr, 64'h1002);
`else
    check("lw_al_req", dbus_req, 1'b1);
    check("lw_al_addr", dbus_addr, 64'h1000);
    grant_and_respond(64'hDEAD_BEEF_8765_4321, 1'b0);
    check("lw_al_data", wb_data, 64'hFFFF_FFFF_8765_4321);
    check("lw_al_exc", wb_exc, 1'b0);
`endif
    release_wb();

    // LD with no grant: timeout after 4 request cycles
    issue(OP_LD, 64'h2000, 64'h0, 64'h0, 5'd8);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_req_%0d", i), dbus_req, 1'b1);
      tick();
    end
    check("to_req_drop", dbus_req, 1'b0);
    check("to_wb_valid", wb_valid, 1'b1);
    check("to_exc", wb_exc, 1'b1);
    check("to_code", wb_exc_code, 2'd2);
    check("to_data", wb_data, 64'h0);
    release_wb();

    // SD with grant already high, then WB backpressure with EX offering
    dbus_gnt = 1'b1;
    issue(OP_SD, 64'h3000, 64'h0, 64'hA5A5_5A5A_0123_4567, 5'd9);
    check("sd_be", dbus_be, 8'hFF);
    check("sd_wdata", dbus_wdata, 64'hA5A5_5A5A_0123_4567);
    tick();
    dbus_gnt = 1'b0;
    check("sd_req_drop", dbus_req, 1'b0);
    dbus_rvalid = 1'b1;
    tick();
    dbus_rvalid = 1'b0;
    in_valid  = 1'b1;
    in_op     = OP_LBU;
    in_base   = 64'h3000;
    in_offset = 64'h5;
    in_rd     = 5'd10;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_valid_%0d", i), wb_valid, 1'b1);
      check($sformatf("bp_ready_%0d", i), in_ready, 1'b0);
      check($sformatf("bp_rd_%0d", i), wb_rd, 5'd9);
      check($sformatf("bp_exc_%0d", i), wb_exc, 1'b0);
      tick();
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    check("bp_released", wb_valid, 1'b0);
    check("bp_ready_back", in_ready, 1'b1);
    check("bp_not_taken", dbus_req, 1'b0);
    tick();
    in_valid = 1'b0;
    check("lbu_req", dbus_req, 1'b1);
    check("lbu_addr", dbus_addr, 64'h3005);
    grant_and_respond(64'h0000_F000_0000_0000, 1'b0);
    check("lbu_data", wb_data, 64'h0000_0000_0000_00F0);
    check("lbu_rd", wb_rd, 5'd10);
    release_wb();

    // bus error on a load
    issue(OP_LW, 64'h4000, 64'h4, 64'h0, 5'd11);
    grant_and_respond(64'h1111_2222_3333_4444, 1'b1);
    check("err_exc", wb_exc, 1'b1);
    check("err_code", wb_exc_code, 2'd1);
    check("err_data", wb_data, 64'h0);
    check("err_addr", wb_addr, 64'h4004);
    release_wb();

    // illegal size and a non-memory op
    issue(OP_BAD, 64'h5000, 64'h1, 64'h0, 5'd12);
    check("ill_req", dbus_req, 1'b0);
    check("ill_valid", wb_valid, 1'b1);
    check("ill_code", wb_exc_code, 2'd3);
    release_wb();
    issue(7'b0, 64'h6000, 64'h0, 64'h0, 5'd13);
    check("nomem_ready", in_ready, 1'b1);
    check("nomem_req", dbus_req, 1'b0);
    check("nomem_valid", wb_valid, 1'b0);

    // reset while waiting; the late response must be dropped
    issue(OP_LB, 64'h7000, 64'h0, 64'h0, 5'd14);
    dbus_gnt = 1'b1;
    tick();
    dbus_gnt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rw_req", dbus_req, 1'b0);
    check("rw_valid", wb_valid, 1'b0);
    check("rw_ready", in_ready, 1'b1);
    tick();
    dbus_rvalid = 1'b1;
    dbus_rdata  = 64'h7F;
    tick();
    dbus_rvalid = 1'b0;
    check("rw_stale_valid", wb_valid, 1'b0);
    check("rw_stale_ready", in_ready, 1'b1);
    check("rw_stale_data", wb_data, 64'h0);
    tick();
    check("rw_stale_valid2", wb_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
